// File: rtl/data_mem_if.sv
// Load/store request/response bus between the load/store unit (master) and the data RAM responder (slave).
// Handshake: a request transfers on a rising clk edge where req_valid && req_ready; resp_valid is a one-cycle strobe.
interface data_mem_if;
   logic         req_valid;
   logic         req_ready;
   logic         req_write;
   logic         req_vector;
   logic [31:0]  req_addr;
   logic [127:0] req_wdata;
   logic         resp_valid;
   logic         resp_err;
   logic [127:0] resp_rdata;

   modport master (
      output req_valid, req_write, req_vector, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_err, resp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_vector, req_addr, req_wdata,
      output req_ready, resp_valid, resp_err, resp_rdata
   );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data RAM serving scalar and VEC_LEN-word read/write requests,
// with one 128-bit response per request and optional wait states per beat.
module data_mem_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          VEC_LEN     = 4,
   parameter int          WAIT_CYCLES = 0,
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter string       INIT_FILE   = ""
) (
   input  logic       clk,
   input  logic       reset,
   data_mem_if.slave  bus,
   output logic [1:0] dbg_state
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int BW = $clog2(VEC_LEN + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

   state_t         state;
   logic [31:0]    base_idx;
   logic           write_q;
   logic           vector_q;
   logic [127:0]   wdata_q;
   logic [BW-1:0]  beat;
   logic [3:0]     wait_cnt;

   logic [31:0]    mem [DEPTH_WORDS];

   logic [31:0]    offset;
   logic [31:0]    first_idx;
   logic [31:0]    last_idx;
   logic [31:0]    cur_idx;
   logic           illegal;
   logic           beat_done;
   logic           last_beat;

   // The whole burst must fit below DEPTH_WORDS; addresses never wrap.
   always_comb begin
      offset    = bus.req_addr - BASE_ADDR;
      first_idx = offset >> 2;
      last_idx  = first_idx + (bus.req_vector ? 32'(VEC_LEN - 1) : 32'd0);
      illegal   = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr < BASE_ADDR) ||
                  (last_idx >= 32'(DEPTH_WORDS));
      cur_idx   = base_idx + 32'(beat);
      beat_done = (wait_cnt == 4'(WAIT_CYCLES));
      last_beat = vector_q ? (beat == BW'(VEC_LEN - 1)) : 1'b1;
   end

   // RAM contents survive reset; writes are gated by state, which reset clears at once.
   always_ff @(posedge clk) begin
      if (state == ACCESS && write_q && beat_done)
         mem[cur_idx[AW-1:0]] <= wdata_q[32*beat +: 32];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         bus.req_ready  <= 1'b1;
         bus.resp_valid <= 1'b0;
         bus.resp_err   <= 1'b0;
         bus.resp_rdata <= '0;
         base_idx       <= '0;
         write_q        <= 1'b0;
         vector_q       <= 1'b0;
         wdata_q        <= '0;
         beat           <= '0;
         wait_cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  base_idx       <= first_idx;
                  write_q        <= bus.req_write;
                  vector_q       <= bus.req_vector;
                  wdata_q        <= bus.req_wdata;
                  beat           <= '0;
                  wait_cnt       <= '0;
                  bus.req_ready  <= 1'b0;
                  bus.resp_rdata <= '0;
                  if (illegal) begin
                     state          <= RESP;
                     bus.resp_valid <= 1'b1;
                     bus.resp_err   <= 1'b1;
                  end else begin
                     state          <= ACCESS;
                     bus.resp_err   <= 1'b0;
                  end
               end
            end
            ACCESS: begin
               if (beat_done) begin
                  wait_cnt <= '0;
                  if (!write_q)
                     bus.resp_rdata[32*beat +: 32] <= mem[cur_idx[AW-1:0]];
                  if (last_beat) begin
                     state          <= RESP;
                     bus.resp_valid <= 1'b1;
                  end else begin
                     beat <= beat + 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            RESP: begin
               state          <= IDLE;
               bus.resp_valid <= 1'b0;
               bus.req_ready  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: scoreboard queues filled at accept time,
// drained by per-DUT monitors that check data, error flag and response cycle.
module tb_data_mem_responder;
   localparam int DEPTH = 1024;
   localparam int EW    = 161;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   data_mem_if bus0();
   data_mem_if bus2();
   logic [1:0] st0, st2;

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0), .dbg_state(st0));
   data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut2 (
      .clk(clk), .reset(reset), .bus(bus2), .dbg_state(st2));

   // entry = {err, rdata, expected response cycle}
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] exp2_q[$];
   int compared = 0;
   int mismatched = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   logic [EW-1:0] e0, e2;
   always @(negedge clk) begin
      if (!reset && bus0.resp_valid) begin
         if (exp_q.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL unexpected_resp0: got resp_valid=1 at cycle %0d want none", cyc);
         end else begin
            e0 = exp_q.pop_front();
            check("err0", 128'(bus0.resp_err), 128'(e0[160]));
            check("rdata0", bus0.resp_rdata, e0[159:32]);
            check("latency0", 128'(cyc), 128'(e0[31:0]));
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && bus2.resp_valid) begin
         if (exp2_q.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL unexpected_resp2: got resp_valid=1 at cycle %0d want none", cyc);
         end else begin
            e2 = exp2_q.pop_front();
            check("err2", 128'(bus2.resp_err), 128'(e2[160]));
            check("rdata2", bus2.resp_rdata, e2[159:32]);
            check("latency2", 128'(cyc), 128'(e2[31:0]));
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic issue(input bit sel, input bit wr, input bit vec, input logic [31:0] addr,
                        input logic [127:0] wd, input bit push, input bit err,
                        input logic [127:0] rd, input int lat, output int acc);
      int t = 0;
      if (sel) begin
         bus2.req_valid = 1'b1; bus2.req_write = wr; bus2.req_vector = vec;
         bus2.req_addr = addr; bus2.req_wdata = wd;
      end else begin
         bus0.req_valid = 1'b1; bus0.req_write = wr; bus0.req_vector = vec;
         bus0.req_addr = addr; bus0.req_wdata = wd;
      end
      while (!(sel ? bus2.req_ready : bus0.req_ready) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         compared++; mismatched++;
         $display("FAIL accept_timeout: got req_ready=0 for %0d cycles want accept", t);
      end
      acc = cyc;
      if (push) begin
         if (sel) exp2_q.push_back({err, rd, 32'(acc + lat)});
         else     exp_q.push_back({err, rd, 32'(acc + lat)});
      end
      @(negedge clk);
      if (sel) bus2.req_valid = 1'b0;
      else     bus0.req_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_q.size() != 0 || exp2_q.size() != 0) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         compared++; mismatched++;
         $display("FAIL drain_timeout: got %0d/%0d pending want 0", exp_q.size(), exp2_q.size());
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, acc_b;
      bit bad;
      bus0.req_valid = 0; bus0.req_write = 0; bus0.req_vector = 0; bus0.req_addr = 0; bus0.req_wdata = 0;
      bus2.req_valid = 0; bus2.req_write = 0; bus2.req_vector = 0; bus2.req_addr = 0; bus2.req_wdata = 0;
      repeat (2) @(negedge clk);
      check("rst_ready0", 128'(bus0.req_ready), 128'd1);
      check("rst_valid0", 128'(bus0.resp_valid), 128'd0);
      check("rst_err0", 128'(bus0.resp_err), 128'd0);
      check("rst_rdata0", bus0.resp_rdata, 128'd0);
      check("rst_state0", 128'(st0), 128'd0);
      check("rst_ready2", 128'(bus2.req_ready), 128'd1);
      reset = 1'b0;
      @(negedge clk);

      // scalar write/read
      issue(0, 1, 0, 32'h10, 128'hDEADBEEF, 1, 0, 128'd0, 2, acc);
      issue(0, 0, 0, 32'h10, 128'd0, 1, 0, 128'hDEADBEEF, 2, acc);
      drain();

      // vector write/read and scalar read inside the burst
      issue(0, 1, 1, 32'h20, {32'd4, 32'd3, 32'd2, 32'd1}, 1, 0, 128'd0, 5, acc);
      issue(0, 0, 1, 32'h20, 128'd0, 1, 0, {32'd4, 32'd3, 32'd2, 32'd1}, 5, acc);
      issue(0, 0, 0, 32'h28, 128'd0, 1, 0, 128'd3, 2, acc);
      drain();
      repeat (3) @(negedge clk);
      check("rdata_hold", bus0.resp_rdata, 128'd3);

      // top-of-RAM boundary and illegal requests
      issue(0, 1, 1, 32'(4*(DEPTH-4)), {32'h44, 32'h33, 32'h22, 32'h11}, 1, 0, 128'd0, 5, acc);
      issue(0, 1, 0, 32'h22, 128'hFFFF, 1, 1, 128'd0, 1, acc);
      issue(0, 1, 1, 32'(4*(DEPTH-2)), {4{32'hFFFFFFFF}}, 1, 1, 128'd0, 1, acc);
      issue(0, 0, 0, 32'(4*DEPTH), 128'd0, 1, 1, 128'd0, 1, acc);
      issue(0, 0, 1, 32'h20, 128'd0, 1, 0, {32'd4, 32'd3, 32'd2, 32'd1}, 5, acc);
      issue(0, 0, 1, 32'(4*(DEPTH-4)), 128'd0, 1, 0, {32'h44, 32'h33, 32'h22, 32'h11}, 5, acc);
      drain();

      // reset during beat 2 of a vector write
      issue(0, 1, 1, 32'h40, {32'h0d, 32'h0c, 32'h0b, 32'h0a}, 1, 0, 128'd0, 5, acc);
      drain();
      issue(0, 1, 1, 32'h40, {32'hdd, 32'hcc, 32'hbb, 32'haa}, 0, 0, 128'd0, 0, acc);
      while (cyc < acc + 3) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_state", 128'(st0), 128'd0);
      check("midrst_valid", 128'(bus0.resp_valid), 128'd0);
      check("midrst_ready", 128'(bus0.req_ready), 128'd1);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("postrst_ready", 128'(bus0.req_ready), 128'd1);
      issue(0, 0, 1, 32'h40, 128'd0, 1, 0, {32'h0d, 32'h0c, 32'hbb, 32'haa}, 5, acc);
      drain();

      // request held while busy is taken in the first IDLE cycle
      issue(0, 1, 0, 32'h84, 128'h66, 1, 0, 128'd0, 2, acc);
      issue(0, 1, 0, 32'h88, 128'h77, 1, 0, 128'd0, 2, acc_b);
      check("accept_gap", 128'(acc_b - acc), 128'd3);
      issue(0, 0, 0, 32'h84, 128'd0, 1, 0, 128'h66, 2, acc);
      issue(0, 0, 0, 32'h88, 128'd0, 1, 0, 128'h77, 2, acc);
      drain();

      // two wait states per beat
      issue(1, 1, 1, 32'h0, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1, 0, 128'd0, 13, acc);
      drain();
      issue(1, 0, 1, 32'h0, 128'd0, 1, 0, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 13, acc);
      bad = 1'b0;
      while (cyc <= acc + 13) begin
         if (bus2.req_ready) bad = 1'b1;
         @(negedge clk);
      end
      check("ready_busy2", 128'(bad), 128'd0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
